parity_err_logger: RTL
======================

# parity_err_logger

Downstream consumer of the parity summary stage. It counts parity-error pulses and captures a first-error snapshot (RAM map plus bunch-crossing number). It also logs each newly-flagged RAM into a small first-word-fall-through event FIFO that VME reads. It converts the sticky 49-bit bad-RAM map into time-stamped, per-RAM events for diagnostics.

## Interface
Parameters:
- MXRAM, 49: width of bad-RAM map (42 cfeb + 5 rpc + 2 mini).
- LOG_DEPTH, 8: event FIFO depth, power of 2.
- CNT_W, 16: error counter width.

Ports:
- clock  in  1  40 MHz TMB main clock.
- global_reset_n  in  1  asynchronous, active-low reset.
- perr_reset  in  1  synchronous clear of all logger state, active-high.
- perr_en  in  1  parity latch enable from the parity summary stage.
- perr_pulse  in  1  one-cycle-per-error-clock pulse from the parity summary stage.
- perr_ram_ff  in  MXRAM  sticky bad-RAM map.
- bxn_counter  in  12  current bunch-crossing number.
- log_rd  in  1  pop head of event FIFO.
- perr_count  out  CNT_W  saturating error-pulse count.
- first_err_vld  out  1  first-error snapshot captured.
- first_err_map  out  MXRAM  perr_ram_ff at first capture.
- first_err_bxn  out  12  bxn at first capture.
- log_empty  out  1  event FIFO empty.
- log_rdata  out  19  head entry, {multi[18], ram_idx[17:12], bxn[11:0]}.
- log_wcnt  out  4  entries held, 0..LOG_DEPTH.
- log_ovf  out  1  sticky: an event was dropped.

## Operation
- Reset (async, or sync perr_reset) values: all outputs 0, except log_empty=1. The prev-map register is also 0.
- Counter: `perr_count` increments when `perr_pulse`=1 and `perr_en`=1. It saturates at all-ones and never wraps.
- Snapshot: on the first cycle with `perr_en`=1 and `perr_ram_ff`≠0 while `first_err_vld`=0, register `first_err_map`, `first_err_bxn` and `first_err_vld`=1. These hold until reset.
- New-bit detect: `new = perr_ram_ff & ~prev`, evaluated only when `perr_en`=1.
  - `prev` updates every cycle to `perr_ram_ff`.
  - When `perr_en`=0, `prev` is forced to 0, matching the upstream map clear.
- Event push: when `new`≠0, push one entry.
  - `ram_idx` is the index of the lowest set bit of `new`.
  - `multi`=1 if more than one bit is set in `new`.
  - `bxn` is the current `bxn_counter`.
- FIFO is first-word-fall-through: `log_rdata` is valid whenever `log_empty`=0.
  - `log_rd` while empty is ignored.
  - Push while full with no pop: the entry is dropped, `log_ovf` is set, and contents are unchanged.
  - Push and pop in the same cycle: both happen. This holds when full, which gives an accepted write and unchanged `log_wcnt`. When empty, only the push takes effect.
- Pointers are log2(LOG_DEPTH) bits and wrap modulo LOG_DEPTH. `log_wcnt` carries one extra bit.

## Timing
- `perr_count` reflects a pulse 1 clock after the pulse.
- Snapshot outputs are valid 1 clock after the qualifying cycle.
- Event push latency: a bit rising in `perr_ram_ff` at edge N appears at the head, if the FIFO was empty, with `log_empty`=0 after edge N+1.
- Pop: after the `log_rd` edge, `log_rdata` presents the next entry in the same cycle. `log_wcnt` decrements at that edge.
- `perr_reset` has priority over all same-cycle pushes, pops and increments.

## Configuration
- `PARITY_EVENT_LOG_EN` defined: the event FIFO, new-bit detect and `log_*` outputs are implemented as above.
- Not defined: no FIFO storage is built. Outputs are tied off: `log_empty`=1, `log_rdata`=0, `log_wcnt`=0, `log_ovf`=0. `log_rd` is ignored. The counter and snapshot are unaffected.

## Structure
- Shared package `parity_pkg` holds:
  - MXRAM=49.
  - Event entry width 19 and the field offsets (`bxn` 11:0, `ram_idx` 17:12, `multi` 18).
  - RAM index base constants: CFEB0=0, RPC=42, MINI=47.
- Sub-module `perr_log_fifo` is the FWFT FIFO with overflow flag. It is instantiated only under `PARITY_EVENT_LOG_EN`.
- Lowest-set-bit encoder is a function in the package.

## Test plan
- Async reset mid-operation, with the counter at 5 and 3 entries logged -> all outputs 0 immediately, `log_empty`=1. No activity until the next error.
- `perr_en`=1, 3 `perr_pulse` cycles -> `perr_count`=3. Preload near-saturation (0xFFFE) plus 4 pulses -> holds 0xFFFF.
- `perr_ram_ff` goes 0 → 0x0_0000_0000_0040 at bxn=0x123 -> `first_err_vld`=1, `first_err_bxn`=0x123. Entry is {0,6,0x123}. A later bit 42 at bxn=0x200 -> second entry {0,42,0x200}; snapshot unchanged.
- Bits 47 and 48 rise together at bxn=0x010 -> single entry {1,47,0x010}.
- 9 distinct bits rise on 9 successive cycles with no reads -> `log_wcnt`=8, `log_ovf`=1, head is the first event. A pop concurrent with a 10th event when full -> `log_wcnt` stays 8 and the 10th event is accepted.
- `perr_en`=0 with a nonzero map -> no count, no snapshot, no push. `perr_reset` pulse -> counter, snapshot, FIFO and `log_ovf` all cleared.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity error logger: map width, event entry layout,
// RAM index bases and the new-bit encoding helpers.
package parity_pkg;

    localparam int MXRAM = 49;

    localparam int EVT_W         = 19;
    localparam int EVT_BXN_LSB   = 0;
    localparam int EVT_BXN_MSB   = 11;
    localparam int EVT_IDX_LSB   = 12;
    localparam int EVT_IDX_MSB   = 17;
    localparam int EVT_MULTI_BIT = 18;

    localparam int RAM_CFEB0 = 0;
    localparam int RAM_RPC   = 42;
    localparam int RAM_MINI  = 47;

    // Scans from the top so the last hit written is the lowest set bit.
    function automatic logic [5:0] lowest_set_idx(input logic [MXRAM-1:0] map);
        logic [5:0] idx;
        idx = '0;
        for (int i = MXRAM - 1; i >= 0; i--) begin
            if (map[i]) begin
                idx = 6'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic multi_bit(input logic [MXRAM-1:0] map);
        return (map & (map - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/perr_log_fifo.sv
// First-word-fall-through event FIFO with a sticky overflow flag; a push into a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module perr_log_fifo
    import parity_pkg::*;
#(
    parameter int W     = EVT_W,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic                       empty_o,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH):0]     wcnt_o,
    output logic                       ovf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          ovf_q;
    logic          do_pop, do_push;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
            if (push_i && !do_push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage carries no reset; the read port is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) begin
            mem[wptr_q] <= wdata_i;
        end
    end

    assign empty_o = (cnt_q == '0);
    assign rdata_o = empty_o ? '0 : mem[rptr_q];
    assign wcnt_o  = cnt_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/parity_err_logger.sv
// Parity error logger: saturating error count, first-error snapshot and, when
// PARITY_EVENT_LOG_EN is defined, a per-RAM event FIFO; otherwise log_* are tied off.
module parity_err_logger #(
    parameter int MXRAM     = parity_pkg::MXRAM,
    parameter int LOG_DEPTH = 8,
    parameter int CNT_W     = 16
) (
    input  logic                              clock,
    input  logic                              global_reset_n,
    input  logic                              perr_reset,
    input  logic                              perr_en,
    input  logic                              perr_pulse,
    input  logic [MXRAM-1:0]                  perr_ram_ff,
    input  logic [11:0]                       bxn_counter,
    input  logic                              log_rd,
    output logic [CNT_W-1:0]                  perr_count,
    output logic                              first_err_vld,
    output logic [MXRAM-1:0]                  first_err_map,
    output logic [11:0]                       first_err_bxn,
    output logic                              log_empty,
    output logic [parity_pkg::EVT_W-1:0]      log_rdata,
    output logic [$clog2(LOG_DEPTH):0]        log_wcnt,
    output logic                              log_ovf
);

    logic [CNT_W-1:0] perr_count_q, perr_count_d;
    logic             first_err_vld_q;
    logic [MXRAM-1:0] first_err_map_q;
    logic [11:0]      first_err_bxn_q;
    logic             snap_take;

    always_comb begin
        perr_count_d = perr_count_q;
        if (perr_en && perr_pulse && (perr_count_q != '1)) begin
            perr_count_d = perr_count_q + 1'b1;
        end
        snap_take = perr_en && (|perr_ram_ff) && !first_err_vld_q;
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            perr_count_q    <= '0;
            first_err_vld_q <= 1'b0;
            first_err_map_q <= '0;
            first_err_bxn_q <= '0;
        end else if (perr_reset) begin
            perr_count_q    <= '0;
            first_err_vld_q <= 1'b0;
            first_err_map_q <= '0;
            first_err_bxn_q <= '0;
        end else begin
            perr_count_q <= perr_count_d;
            if (snap_take) begin
                first_err_vld_q <= 1'b1;
                first_err_map_q <= perr_ram_ff;
                first_err_bxn_q <= bxn_counter;
            end
        end
    end

    assign perr_count    = perr_count_q;
    assign first_err_vld = first_err_vld_q;
    assign first_err_map = first_err_map_q;
    assign first_err_bxn = first_err_bxn_q;

`ifdef PARITY_EVENT_LOG_EN
    logic [MXRAM-1:0]              prev_q, prev_d;
    logic [MXRAM-1:0]              new_bits;
    logic [parity_pkg::EVT_W-1:0]  evt;

    // prev follows the map only while enabled, mirroring the upstream clear.
    assign prev_d   = perr_en ? perr_ram_ff : '0;
    assign new_bits = perr_en ? (perr_ram_ff & ~prev_q) : '0;
    assign evt      = {parity_pkg::multi_bit(new_bits),
                       parity_pkg::lowest_set_idx(new_bits),
                       bxn_counter};

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            prev_q <= '0;
        end else if (perr_reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    perr_log_fifo #(
        .W     (parity_pkg::EVT_W),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk_i   (clock),
        .rst_n_i (global_reset_n),
        .clr_i   (perr_reset),
        .push_i  (|new_bits),
        .wdata_i (evt),
        .pop_i   (log_rd),
        .empty_o (log_empty),
        .rdata_o (log_rdata),
        .wcnt_o  (log_wcnt),
        .ovf_o   (log_ovf)
    );
`else
    logic unused_log_rd;
    assign unused_log_rd = log_rd;

    assign log_empty = 1'b1;
    assign log_rdata = '0;
    assign log_wcnt  = '0;
    assign log_ovf   = 1'b0;
`endif

endmodule
